// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : byte-serial program loader for the instruction memory.
// Packs little-endian bytes into 32-bit words and holds the core in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W:0]     r_len;
  logic [1:0]          r_idx;
  logic [31:0]         r_asm;
  logic                r_byte_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_core_rst;
  logic                r_done;
  logic [ADDR_W:0]     r_word_count;

  logic                w_start;
  logic                w_accept;
  logic [ADDR_W:0]     w_len_clamp;
  logic [ADDR_W:0]     w_wc_inc;

  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
  // byte_ready is only ever high in RECV, so this also gates by state
  assign w_accept    = byte_valid && r_byte_ready;
  assign w_len_clamp = (load_len > c_depth) ? c_depth : load_len;
  assign w_wc_inc    = r_word_count + c_one;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = (w_len_clamp == '0) ? S_DONE : S_RECV;
      S_RECV:         if (w_accept && r_idx == 2'd3) w_next = S_WRITE;
      S_WRITE:        w_next = (w_wc_inc == r_len) ? S_DONE : S_RECV;
      default:        w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_ready <= 1'b0;
      r_core_rst   <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_byte_ready <= (w_next == S_RECV);
      r_core_rst   <= (w_next != S_DONE);
      r_done       <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len        <= '0;
      r_idx        <= 2'd0;
      r_asm        <= 32'd0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= 32'd0;
      r_word_count <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_len        <= w_len_clamp;
        r_word_count <= '0;
        r_waddr      <= '0;
        r_idx        <= 2'd0;
      end else if (r_state == S_RECV && w_accept) begin
        r_asm[{r_idx, 3'b000} +: 8] <= byte_data;
        r_idx                       <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_we    <= 1'b1;
          r_wdata <= {byte_data, r_asm[23:0]};
        end
      end else if (r_state == S_WRITE) begin
        r_waddr      <= r_waddr + 1'b1;
        r_word_count <= w_wc_inc;
        r_idx        <= 2'd0;
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign core_rst   = r_core_rst;
  assign done       = r_done;
  assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader : scoreboard bench for imem_loader (depth-4 instance).
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  logic [AW+31:0] sb_q[$];
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Write monitor: every strobe must match the oldest expected word
  always @(negedge clk) begin
    if (imem_we) begin
      logic [AW+31:0] e;
      n_writes++;
      chk("we_pulse", {31'd0, prev_we}, 32'd0);
      if (sb_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("waddr", {{(32-AW){1'b0}}, imem_waddr}, {{(32-AW){1'b0}}, e[AW+31:32]});
        chk("wdata", imem_wdata, e[31:0]);
      end
    end
    prev_we = imem_we;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    start = 1'b1; load_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    byte_valid = 1'b0;
    repeat ($urandom_range(maxgap, 0)) begin
      byte_data = 8'($urandom);
      step();
    end
    byte_valid = 1'b1; byte_data = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w, input int maxgap);
    sb_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], maxgap);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("done_reached", {31'd0, done}, 32'd1);
    step();
  endtask

  int w0;

  initial begin
    rst = 1'b0; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_waddr", {30'd0, imem_waddr}, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    step(); rst = 1'b1; step();

    // reset mid-RECV after two bytes discards the partial word
    pulse_start(3'd2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
    chk("midrst_wc", {29'd0, word_count}, 32'd0);
    step(); rst = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (3) step();
    byte_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);
    chk("idle_core_rst", {31'd0, core_rst}, 32'd1);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("midrst_writes", n_writes, 0);
    step();

    // zero length: DONE on the cycle after start
    pulse_start(3'd0);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_core_rst", {31'd0, core_rst}, 32'd0);
    chk("zero_wc", {29'd0, word_count}, 32'd0);
    step();
    chk("zero_writes", n_writes, 0);

    // single word, back-to-back bytes
    pulse_start(3'd1);
    send_word(2'd0, 32'h003100B3, 0);
    @(negedge clk);
    chk("single_we", {31'd0, imem_we}, 32'd1);
    chk("single_wdata", imem_wdata, 32'h003100B3);
    @(negedge clk);
    chk("single_done", {31'd0, done}, 32'd1);
    chk("single_core_rst", {31'd0, core_rst}, 32'd0);
    chk("single_wc", {29'd0, word_count}, 32'd1);
    step();

    // reload from DONE
    pulse_start(3'd2);
    @(negedge clk);
    chk("reload_core_rst", {31'd0, core_rst}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    chk("reload_waddr", {30'd0, imem_waddr}, 32'd0);
    step();
    send_word(2'd0, 32'h12345678, 0);
    send_word(2'd1, 32'h9ABCDEF0, 0);
    wait_done();
    chk("reload_core_rst_end", {31'd0, core_rst}, 32'd0);
    chk("reload_wc", {29'd0, word_count}, 32'd2);

    // multi-word with random idle gaps
    w0 = n_writes;
    pulse_start(3'd3);
    for (int i = 0; i < 3; i++) send_word(AW'(i), $urandom, 3);
    wait_done();
    chk("multi_writes", n_writes - w0, 3);
    chk("multi_wc", {29'd0, word_count}, 32'd3);

    // clamp: 7 requested, depth 4
    w0 = n_writes;
    pulse_start(3'd7);
    for (int i = 0; i < 4; i++) send_word(AW'(i), $urandom, 1);
    wait_done();
    chk("clamp_writes", n_writes - w0, 4);
    chk("clamp_wc", {29'd0, word_count}, 32'd4);
    byte_valid = 1'b1; byte_data = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_done_ready", {31'd0, byte_ready}, 32'd0);
      step();
    end
    byte_valid = 1'b0;
    step();
    chk("after_done_writes", n_writes - w0, 4);
    chk("after_done_wc", {29'd0, word_count}, 32'd4);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
